dcp_tlb_responder: RTL and testbench

// - Slave/responder end of the DCP valid-ack TLB translation interface; answers vpn requests with ppn + 1-cycle ack.
// - Small fully-associative TLB cache in front of an external page-table walker (PTW) port.
// - Hits are acked 1 cycle after acceptance; misses issue a PTW request, fill the array, then ack.
// - Sits between cohort DCP engines (TLB masters) and the tile PTW.

---
 rtl/dcp_pkg.sv | 24 ++
 rtl/dcp_tlb_cam.sv | 74 +++++++
 rtl/dcp_tlb_responder.sv | 141 ++++++++++++++
 tb/tb_dcp_tlb_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcp_pkg.sv
// Shared types for the DCP TLB responder: FSM states, widths and the entry layout.
// DCP_VADDR sets the virtual address width; vpn/ppn width is DCP_VADDR-12 (4 KiB pages).
`ifndef DCP_VADDR
`define DCP_VADDR 40
`endif

package dcp_pkg;

    localparam int unsigned TLB_VPN_W = `DCP_VADDR - 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WREQ = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } tlb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TLB_VPN_W-1:0] vpn;
        logic [TLB_VPN_W-1:0] ppn;
    } tlb_entry_t;

endpackage

// File: rtl/dcp_tlb_cam.sv
// Fully-associative TLB entry array: parallel vpn compare, fill into the first free
// entry or the round-robin victim, and single-cycle flush of all valid bits.
module dcp_tlb_cam
    import dcp_pkg::*;
#(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned VPN_W   = TLB_VPN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             hit_c,
    output logic [VPN_W-1:0] hit_ppn_c,
    input  logic             fill_en,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [VPN_W-1:0] fill_ppn
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [VPN_W-1:0]   ppn_q [ENTRIES];
    logic [IDX_W-1:0]   victim;
    logic [IDX_W-1:0]   fill_idx_c;
    logic               free_found_c;

    // Vpns are unique in the array, so OR-merging matching ppns yields the single hit.
    always_comb begin
        hit_c     = 1'b0;
        hit_ppn_c = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid[i] && (vpn_q[i] == lookup_vpn)) begin
                hit_c     = 1'b1;
                hit_ppn_c = hit_ppn_c | ppn_q[i];
            end
        end
    end

    // Lowest-numbered invalid entry wins; otherwise the victim pointer is used.
    always_comb begin
        fill_idx_c   = victim;
        free_found_c = 1'b0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                fill_idx_c   = IDX_W'(i);
                free_found_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            victim <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                vpn_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else if (flush) begin
            valid  <= '0;
            victim <= '0;
        end else if (fill_en) begin
            valid[fill_idx_c] <= 1'b1;
            vpn_q[fill_idx_c] <= fill_vpn;
            ppn_q[fill_idx_c] <= fill_ppn;
            if (!free_found_c) begin
                victim <= victim + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/dcp_tlb_responder.sv
// Responder end of the DCP valid-ack TLB interface with a small TLB in front of the PTW.
// Define DCP_TLB_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module dcp_tlb_responder
    import dcp_pkg::*;
#(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned VPN_W   = TLB_VPN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tlb_valid,
    input  logic [VPN_W-1:0] tlb_vpn,
    output logic             tlb_ack,
    output logic [VPN_W-1:0] tlb_ppn,
    input  logic             flush,
    output logic             ptw_req_val,
    input  logic             ptw_req_rdy,
    output logic [VPN_W-1:0] ptw_req_vpn,
    input  logic             ptw_resp_val,
    input  logic [VPN_W-1:0] ptw_resp_ppn
`ifdef DCP_TLB_STATS_EN
    ,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_misses
`endif
);

    tlb_state_e       state_q, state_d;
    logic             ack_d;
    logic [VPN_W-1:0] ppn_d;
    logic             preq_val_d;
    logic [VPN_W-1:0] preq_vpn_d;
    logic             flushed_q, flushed_d;
    logic             fill_en_c;
    logic             cam_hit_c;
    logic [VPN_W-1:0] cam_ppn_c;

    dcp_tlb_cam #(
        .ENTRIES (ENTRIES),
        .VPN_W   (VPN_W)
    ) u_cam (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .lookup_vpn (tlb_vpn),
        .hit_c      (cam_hit_c),
        .hit_ppn_c  (cam_ppn_c),
        .fill_en    (fill_en_c),
        .fill_vpn   (ptw_req_vpn),
        .fill_ppn   (ptw_resp_ppn)
    );

    // ptw_req_vpn doubles as the latched request vpn used for the fill.
    // A flush seen during a walk marks its result stale so it is acked but not cached.
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        ppn_d      = tlb_ppn;
        preq_val_d = ptw_req_val;
        preq_vpn_d = ptw_req_vpn;
        flushed_d  = flushed_q;
        fill_en_c  = 1'b0;
        if (flush && (state_q != IDLE)) begin
            flushed_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (tlb_valid) begin
                    if (cam_hit_c && !flush) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        ppn_d   = cam_ppn_c;
                    end else begin
                        state_d    = WREQ;
                        preq_val_d = 1'b1;
                        preq_vpn_d = tlb_vpn;
                        flushed_d  = 1'b0;
                    end
                end
            end
            WREQ: begin
                if (ptw_req_rdy) begin
                    state_d    = WAIT;
                    preq_val_d = 1'b0;
                end
            end
            WAIT: begin
                if (ptw_resp_val) begin
                    state_d   = ACK;
                    ack_d     = 1'b1;
                    ppn_d     = ptw_resp_ppn;
                    fill_en_c = !flush && !flushed_q;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tlb_ack     <= 1'b0;
            tlb_ppn     <= '0;
            ptw_req_val <= 1'b0;
            ptw_req_vpn <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tlb_ack     <= ack_d;
            tlb_ppn     <= ppn_d;
            ptw_req_val <= preq_val_d;
            ptw_req_vpn <= preq_vpn_d;
            flushed_q   <= flushed_d;
        end
    end

`ifdef DCP_TLB_STATS_EN
    logic hit_accept_c;
    logic miss_accept_c;

    assign hit_accept_c  = (state_q == IDLE) && tlb_valid && cam_hit_c && !flush;
    assign miss_accept_c = (state_q == IDLE) && tlb_valid && !(cam_hit_c && !flush);

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (hit_accept_c && (stat_hits != 32'hFFFF_FFFF)) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (miss_accept_c && (stat_misses != 32'hFFFF_FFFF)) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcp_tlb_responder.sv
// Self-checking bench for dcp_tlb_responder: scoreboard of expected ppns, bench-driven PTW.
// Stats checks are compiled in when DCP_TLB_STATS_EN is defined.
module tb_dcp_tlb_responder;
    import dcp_pkg::*;

    localparam int unsigned VW = TLB_VPN_W;

    logic          clk;
    logic          rst_n;
    logic          tlb_valid;
    logic [VW-1:0] tlb_vpn;
    logic          tlb_ack;
    logic [VW-1:0] tlb_ppn;
    logic          flush;
    logic          ptw_req_val;
    logic          ptw_req_rdy;
    logic [VW-1:0] ptw_req_vpn;
    logic          ptw_resp_val;
    logic [VW-1:0] ptw_resp_ppn;
`ifdef DCP_TLB_STATS_EN
    logic [31:0]   stat_hits;
    logic [31:0]   stat_misses;
`endif

    int tests = 0;
    int fails = 0;
    logic [VW-1:0] exp_q [$];

    dcp_tlb_responder #(.ENTRIES(4), .VPN_W(VW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tlb_valid    (tlb_valid),
        .tlb_vpn      (tlb_vpn),
        .tlb_ack      (tlb_ack),
        .tlb_ppn      (tlb_ppn),
        .flush        (flush),
        .ptw_req_val  (ptw_req_val),
        .ptw_req_rdy  (ptw_req_rdy),
        .ptw_req_vpn  (ptw_req_vpn),
        .ptw_resp_val (ptw_resp_val),
        .ptw_resp_ppn (ptw_resp_ppn)
`ifdef DCP_TLB_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request and plays the PTW; the ack ppn is checked against the scoreboard.
    task automatic transact(input logic [VW-1:0] vpn, input logic [VW-1:0] exp_ppn,
                            input logic [VW-1:0] walk_ppn, input int rdy_wait,
                            input int resp_wait, input bit flush_at_req, input bit flush_in_wait,
                            output int lat, output bit walked, output bit stable);
        int phase = 0;
        int rcnt  = 0;
        int wcnt  = 0;
        bit got   = 1'b0;
        logic [VW-1:0] exp_v;
        lat    = 0;
        walked = 1'b0;
        stable = 1'b1;
        exp_q.push_back(exp_ppn);
        @(negedge clk);
        tlb_valid = 1'b1;
        tlb_vpn   = vpn;
        flush     = flush_at_req;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            flush        = 1'b0;
            ptw_resp_val = 1'b0;
            if (tlb_ack) begin
                got         = 1'b1;
                lat         = c;
                tlb_valid   = 1'b0;
                ptw_req_rdy = 1'b0;
                if (ptw_req_val) walked = 1'b1;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty: unexpected ack ppn=%0h", tlb_ppn);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (tlb_ppn !== exp_v) begin
                        fails++;
                        $display("FAIL ack_ppn vpn=%0h: got %0h expected %0h", vpn, tlb_ppn, exp_v);
                    end
                end
            end else begin
                if (phase == 0 && ptw_req_val) begin
                    phase  = 1;
                    walked = 1'b1;
                end
                if (phase == 1) begin
                    if (!ptw_req_val) begin
                        phase       = 2;
                        ptw_req_rdy = 1'b0;
                        if (flush_in_wait) flush = 1'b1;
                    end else begin
                        if (ptw_req_vpn !== vpn) stable = 1'b0;
                        if (rcnt < rdy_wait) begin
                            ptw_req_rdy = 1'b0;
                            rcnt++;
                        end else begin
                            ptw_req_rdy = 1'b1;
                        end
                    end
                end
                if (phase == 2) begin
                    if (wcnt == resp_wait) begin
                        ptw_resp_val = 1'b1;
                        ptw_resp_ppn = walk_ppn;
                        phase        = 3;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout vpn=%0h: no ack within 200 cycles", vpn);
            tlb_valid = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tlb_valid = 1'b0; tlb_vpn = '0; flush = 1'b0;
        ptw_req_rdy = 1'b0; ptw_resp_val = 1'b0; ptw_resp_ppn = '0;
        repeat (3) @(negedge clk);
        tests += 4;
        if (tlb_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %0b expected 0", tlb_ack); end
        if (tlb_ppn !== '0) begin fails++; $display("FAIL reset_ppn: got %0h expected 0", tlb_ppn); end
        if (ptw_req_val !== 1'b0) begin fails++; $display("FAIL reset_req_val: got %0b expected 0", ptw_req_val); end
        if (ptw_req_vpn !== '0) begin fails++; $display("FAIL reset_req_vpn: got %0h expected 0", ptw_req_vpn); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        int lat; bit walked; bit stable;
        transact(VW'(32'h12345), VW'(32'h0ABCD), VW'(32'h0ABCD), 0, 3, 1'b0, 1'b0, lat, walked, stable);
        tests += 2;
        if (!walked) begin fails++; $display("FAIL cold_walk: got 0 expected 1"); end
        if (lat != 6) begin fails++; $display("FAIL cold_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_hit();
        int lat; bit walked; bit stable;
        transact(VW'(32'h12345), VW'(32'h0ABCD), VW'(32'h0), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        tests += 2;
        if (walked) begin fails++; $display("FAIL hit_walk: got 1 expected 0"); end
        if (lat != 1) begin fails++; $display("FAIL hit_latency: got %0d expected 1", lat); end
        @(negedge clk);
        tests++;
        if (tlb_ack !== 1'b0) begin fails++; $display("FAIL ack_single_cycle: got %0b expected 0", tlb_ack); end
        @(negedge clk);
        tests++;
        if (tlb_ppn !== VW'(32'h0ABCD)) begin fails++; $display("FAIL ppn_held: got %0h expected abcd", tlb_ppn); end
    endtask

    task automatic test_backpressure();
        int lat; bit walked; bit stable;
        transact(VW'(32'h2222), VW'(32'h0BEEF), VW'(32'h0BEEF), 5, 1, 1'b0, 1'b0, lat, walked, stable);
        tests += 2;
        if (!stable) begin fails++; $display("FAIL bp_req_stable: got 0 expected 1"); end
        if (lat != 9) begin fails++; $display("FAIL bp_latency: got %0d expected 9", lat); end
    endtask

    task automatic test_flush_idle();
        int lat; bit walked; bit stable;
        transact(VW'(32'h12345), VW'(32'h0ABCD), VW'(32'h0ABCD), 0, 0, 1'b1, 1'b0, lat, walked, stable);
        tests += 2;
        if (!walked) begin fails++; $display("FAIL flush_lookup_walk: got 0 expected 1"); end
        if (lat != 3) begin fails++; $display("FAIL flush_lookup_latency: got %0d expected 3", lat); end
        transact(VW'(32'h12345), VW'(32'h0ABCD), VW'(32'h0), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        tests++;
        if (walked || lat != 1) begin fails++; $display("FAIL refill_hit: got walked=%0b lat=%0d expected walked=0 lat=1", walked, lat); end
    endtask

    task automatic test_flush_wait();
        int lat; bit walked; bit stable;
        transact(VW'(32'h3333), VW'(32'h77), VW'(32'h77), 0, 2, 1'b0, 1'b1, lat, walked, stable);
        tests++;
        if (lat != 5) begin fails++; $display("FAIL flush_wait_latency: got %0d expected 5", lat); end
        transact(VW'(32'h3333), VW'(32'h78), VW'(32'h78), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        tests++;
        if (!walked) begin fails++; $display("FAIL flush_wait_rewalk: got 0 expected 1"); end
        transact(VW'(32'h4444), VW'(32'h44), VW'(32'h44), 0, 0, 1'b0, 1'b1, lat, walked, stable);
        transact(VW'(32'h4444), VW'(32'h45), VW'(32'h45), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        tests++;
        if (!walked) begin fails++; $display("FAIL flush_resp_same_cycle_rewalk: got 0 expected 1"); end
    endtask

    task automatic test_replacement();
        int lat; bit walked; bit stable;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            transact(VW'(v), VW'(32'h100 + v), VW'(32'h100 + v), 0, 1, 1'b0, 1'b0, lat, walked, stable);
            tests++;
            if (!walked) begin fails++; $display("FAIL repl_fill_walk vpn=%0d: got 0 expected 1", v); end
        end
        for (int v = 2; v <= 5; v++) begin
            transact(VW'(v), VW'(32'h100 + v), VW'(32'h0), 0, 0, 1'b0, 1'b0, lat, walked, stable);
            tests++;
            if (walked || lat != 1) begin fails++; $display("FAIL repl_hit vpn=%0d: got walked=%0b lat=%0d expected walked=0 lat=1", v, walked, lat); end
        end
        transact(VW'(1), VW'(32'h201), VW'(32'h201), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        tests++;
        if (!walked) begin fails++; $display("FAIL repl_evicted_walk: got 0 expected 1"); end
    endtask

    task automatic test_reset_midwalk();
        int lat; bit walked; bit stable;
        int n_ack = 0;
        bit seen = 1'b0;
        @(negedge clk);
        tlb_valid = 1'b1; tlb_vpn = VW'(32'h5555);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (ptw_req_val) seen = 1'b1;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL midwalk_req: got 0 expected 1"); end
        ptw_req_rdy = 1'b1;
        @(negedge clk);
        ptw_req_rdy = 1'b0;
        rst_n = 1'b0; tlb_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ptw_resp_val = 1'b1; ptw_resp_ppn = VW'(32'h99);
        @(negedge clk);
        ptw_resp_val = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (tlb_ack) n_ack++;
            @(negedge clk);
        end
        tests += 2;
        if (n_ack != 0) begin fails++; $display("FAIL late_resp_ack: got %0d acks expected 0", n_ack); end
        if (ptw_req_val !== 1'b0) begin fails++; $display("FAIL late_resp_req_val: got %0b expected 0", ptw_req_val); end
        transact(VW'(32'h5555), VW'(32'h55), VW'(32'h55), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        tests++;
        if (!walked) begin fails++; $display("FAIL midwalk_not_filled: got 0 expected 1"); end
    endtask

`ifdef DCP_TLB_STATS_EN
    task automatic test_stats();
        int lat; bit walked; bit stable;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests += 2;
        if (stat_hits !== 32'd0) begin fails++; $display("FAIL stats_reset_hits: got %0d expected 0", stat_hits); end
        if (stat_misses !== 32'd0) begin fails++; $display("FAIL stats_reset_misses: got %0d expected 0", stat_misses); end
        transact(VW'(32'hA1), VW'(32'h1A1), VW'(32'h1A1), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        transact(VW'(32'hA2), VW'(32'h1A2), VW'(32'h1A2), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        transact(VW'(32'hA1), VW'(32'h1A1), VW'(32'h0), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        transact(VW'(32'hA2), VW'(32'h1A2), VW'(32'h0), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        transact(VW'(32'hA1), VW'(32'h1A1), VW'(32'h0), 0, 0, 1'b0, 1'b0, lat, walked, stable);
        @(negedge clk);
        tests += 2;
        if (stat_hits !== 32'd3) begin fails++; $display("FAIL stats_hits: got %0d expected 3", stat_hits); end
        if (stat_misses !== 32'd2) begin fails++; $display("FAIL stats_misses: got %0d expected 2", stat_misses); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        tests += 2;
        if (stat_hits !== 32'd3) begin fails++; $display("FAIL stats_flush_hits: got %0d expected 3", stat_hits); end
        if (stat_misses !== 32'd2) begin fails++; $display("FAIL stats_flush_misses: got %0d expected 2", stat_misses); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_backpressure();
        test_flush_idle();
        test_flush_wait();
        test_replacement();
        test_reset_midwalk();
`ifdef DCP_TLB_STATS_EN
        test_stats();
`endif
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
